// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4:1 mux round-robin arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mux_arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;
   localparam int HOLD_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between four mux masters and the arbiter.
// Latency: wires only; grant-side signals are flop outputs of the arbiter.
// Backpressure: requests are levels, held until granted and served.
// Ports: ARB_req (master->arbiter), ARB_gnt/ARB_sel/ARB_valid/ARB_preempt (arbiter->master).
interface mux4_rr_arbiter_if;
   import mux_arb_pkg::*;

   logic [NUM_REQ-1:0] ARB_req;
   logic [NUM_REQ-1:0] ARB_gnt;
   logic [SEL_W-1:0]   ARB_sel;
   logic               ARB_valid;
   logic               ARB_preempt;

   // Requesting side.
   modport master (
      output ARB_req,
      input  ARB_gnt, ARB_sel, ARB_valid, ARB_preempt
   );

   // Arbiter side.
   modport slave (
      input  ARB_req,
      output ARB_gnt, ARB_sel, ARB_valid, ARB_preempt
   );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
// Latency: combinational, zero cycles.
// Backpressure: none; result is valid whenever found is high.
// Ports: req/ptr in; found, idx (binary winner) and onehot (winner mask) out.
module rr_pick4
   import mux_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic               found,
   output logic [SEL_W-1:0]   idx,
   output logic [NUM_REQ-1:0] onehot
);

   logic [SEL_W-1:0] cand;

   always_comb begin
      found  = 1'b0;
      idx    = ptr;
      onehot = '0;
      cand   = ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         // Index wraps naturally in SEL_W bits.
         cand = ptr + SEL_W'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      if (found) begin
         onehot = NUM_REQ'(1) << idx;
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer driving the select of a shared 4:1 mux, with hold-limit preemption.
// Latency: grant registered one edge after request seen in IDLE/TURN; one dead cycle between owners.
// Backpressure: requests are levels; a non-owner simply waits, owner loses grant on release or hold limit.
// Ports: clk, rst_n (async active-low); arb slave modport carries ARB_req in and ARB_gnt/sel/valid/preempt out.
module mux4_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 15
)
(
   input  logic              clk,
   input  logic              rst_n,
   mux4_rr_arbiter_if.slave  arb
);

   // Compare value for the hold counter; only meaningful when MAX_HOLD != 0.
   localparam int unsigned      HOLD_M1  = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_M1);

   arb_state_t          state;
   logic [SEL_W-1:0]    ptr;
   logic [HOLD_W-1:0]   cnt;

   logic [NUM_REQ-1:0]  gnt_q;
   logic [SEL_W-1:0]    sel_q;
   logic                valid_q;
   logic                preempt_q;

   logic                pick_found;
   logic [SEL_W-1:0]    pick_idx;
   logic [NUM_REQ-1:0]  pick_onehot;

   logic                owner_req;
   logic                release_now;
   logic                preempt_now;

   rr_pick4 u_pick (
      .req    (arb.ARB_req),
      .ptr    (ptr),
      .found  (pick_found),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   // sel_q always names the current owner while in GRANT.
   assign owner_req   = arb.ARB_req[sel_q];
   assign release_now = !owner_req;
   // Release wins over preempt: preempt only counts while the owner still requests.
   assign preempt_now = (MAX_HOLD != 0) && (cnt == HOLD_LIM) && owner_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         cnt       <= '0;
         gnt_q     <= '0;
         sel_q     <= '0;
         valid_q   <= 1'b0;
         preempt_q <= 1'b0;
      end else begin
         preempt_q <= 1'b0;
         case (state)
            IDLE, TURN: begin
               if (pick_found) begin
                  gnt_q   <= pick_onehot;
                  sel_q   <= pick_idx;
                  valid_q <= 1'b1;
                  cnt     <= '0;
                  state   <= GRANT;
               end else begin
                  state   <= IDLE;
               end
            end
            GRANT: begin
               if (release_now || preempt_now) begin
                  gnt_q     <= '0;
                  valid_q   <= 1'b0;
                  preempt_q <= preempt_now;
                  ptr       <= sel_q + 1'b1;
                  state     <= TURN;
               end else if (cnt != '1) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               gnt_q   <= '0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign arb.ARB_gnt     = gnt_q;
   assign arb.ARB_sel     = sel_q;
   assign arb.ARB_valid   = valid_q;
   assign arb.ARB_preempt = preempt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: four instances with different hold limits share clock and reset.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: requests driven as levels from the single stimulus block.
module tb_mux4_rr_arbiter;

   logic clk;
   logic rst_n;

   int tests;
   int fails;

   mux4_rr_arbiter_if if0 ();
   mux4_rr_arbiter_if if4 ();
   mux4_rr_arbiter_if if2 ();
   mux4_rr_arbiter_if if3 ();

   mux4_rr_arbiter #(.MAX_HOLD(0)) u0 (.clk(clk), .rst_n(rst_n), .arb(if0));
   mux4_rr_arbiter #(.MAX_HOLD(4)) u4 (.clk(clk), .rst_n(rst_n), .arb(if4));
   mux4_rr_arbiter #(.MAX_HOLD(2)) u2 (.clk(clk), .rst_n(rst_n), .arb(if2));
   mux4_rr_arbiter #(.MAX_HOLD(3)) u3 (.clk(clk), .rst_n(rst_n), .arb(if3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] observed, input logic [3:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   initial begin
      logic [3:0] exp_gnt;
      tests = 0;
      fails = 0;

      // ---- reset with all requests high ----
      rst_n       = 1'b0;
      if0.ARB_req = 4'b1111;
      if4.ARB_req = 4'b0000;
      if2.ARB_req = 4'b0000;
      if3.ARB_req = 4'b0000;
      step();
      step();
      chk("rst_gnt",     if0.ARB_gnt, 4'b0000);
      chk("rst_sel",     {2'b00, if0.ARB_sel}, 4'd0);
      chk("rst_valid",   {3'b000, if0.ARB_valid}, 4'd0);
      chk("rst_preempt", {3'b000, if0.ARB_preempt}, 4'd0);
      rst_n = 1'b1;

      // ---- rotation, no hold limit: 0,1,2,3,0 with one gap each ----
      for (int k = 0; k < 4; k++) begin
         exp_gnt = 4'b0001 << k;
         for (int c = 0; c < 3; c++) begin
            step();
            chk("rot_gnt",   if0.ARB_gnt, exp_gnt);
            chk("rot_sel",   {2'b00, if0.ARB_sel}, 4'(k));
            chk("rot_valid", {3'b000, if0.ARB_valid}, 4'd1);
         end
         if0.ARB_req[k] = 1'b0;
         step();
         chk("rot_gap_gnt",   if0.ARB_gnt, 4'b0000);
         chk("rot_gap_valid", {3'b000, if0.ARB_valid}, 4'd0);
         chk("rot_gap_sel",   {2'b00, if0.ARB_sel}, 4'(k));
         chk("rot_gap_pre",   {3'b000, if0.ARB_preempt}, 4'd0);
         if0.ARB_req = 4'b1111;
      end
      step();
      chk("rot_wrap_gnt", if0.ARB_gnt, 4'b0001);
      if0.ARB_req = 4'b0000;
      step();
      chk("rot_idle_gnt", if0.ARB_gnt, 4'b0000);

      // ---- preempt with hold limit 4, requests 0101 ----
      if4.ARB_req = 4'b0101;
      for (int rep = 0; rep < 2; rep++) begin
         for (int o = 0; o <= 2; o += 2) begin
            exp_gnt = 4'b0001 << o;
            for (int c = 0; c < 4; c++) begin
               step();
               chk("pre_gnt",   if4.ARB_gnt, exp_gnt);
               chk("pre_quiet", {3'b000, if4.ARB_preempt}, 4'd0);
            end
            step();
            chk("pre_drop_gnt",  if4.ARB_gnt, 4'b0000);
            chk("pre_pulse",     {3'b000, if4.ARB_preempt}, 4'd1);
            chk("pre_drop_sel",  {2'b00, if4.ARB_sel}, 4'(o));
         end
      end
      if4.ARB_req = 4'b0000;

      // ---- sole requester, hold limit 2 ----
      if2.ARB_req = 4'b1000;
      for (int rep = 0; rep < 3; rep++) begin
         for (int c = 0; c < 2; c++) begin
            step();
            chk("solo_gnt", if2.ARB_gnt, 4'b1000);
            chk("solo_sel", {2'b00, if2.ARB_sel}, 4'd3);
         end
         step();
         chk("solo_gap_gnt", if2.ARB_gnt, 4'b0000);
         chk("solo_gap_sel", {2'b00, if2.ARB_sel}, 4'd3);
         chk("solo_gap_pre", {3'b000, if2.ARB_preempt}, 4'd1);
      end
      if2.ARB_req = 4'b0000;

      // ---- release coincides with hold limit 3 ----
      if3.ARB_req = 4'b0010;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("relpre_gnt", if3.ARB_gnt, 4'b0010);
      end
      if3.ARB_req = 4'b0000;
      step();
      chk("relpre_gnt_drop", if3.ARB_gnt, 4'b0000);
      chk("relpre_no_pulse", {3'b000, if3.ARB_preempt}, 4'd0);
      chk("relpre_valid",    {3'b000, if3.ARB_valid}, 4'd0);

      // ---- asynchronous reset mid-grant ----
      // u0 pointer sits at 1 after its last release, so a post-reset grant of bit 0 shows the restart.
      if0.ARB_req = 4'b0100;
      step();
      step();
      chk("ar_pre_gnt", if0.ARB_gnt, 4'b0100);
      chk("ar_pre_sel", {2'b00, if0.ARB_sel}, 4'd2);
      rst_n = 1'b0;
      #2;
      chk("ar_gnt",   if0.ARB_gnt, 4'b0000);
      chk("ar_sel",   {2'b00, if0.ARB_sel}, 4'd0);
      chk("ar_valid", {3'b000, if0.ARB_valid}, 4'd0);
      if0.ARB_req = 4'b1111;
      #1;
      rst_n = 1'b1;
      step();
      chk("ar_restart_gnt", if0.ARB_gnt, 4'b0001);
      chk("ar_restart_sel", {2'b00, if0.ARB_sel}, 4'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
